// File: rtl/top.sv
// Pass-through / 4-sample accumulator: a control FSM sequences an 8-bit
// accumulator and output register; z is always taken straight from the output register.
module top (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] a,
   input  logic       sel,
   output logic [7:0] z
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      ACC1 = 3'd2,
      ACC2 = 3'd3,
      ACC3 = 3'd4
   } state_t;

   state_t     state;
   logic [7:0] acc;
   logic [7:0] zr;
   logic [7:0] sum;
   logic       acc_load;
   logic       acc_add;
   logic       zr_pass;
   logic       zr_sum;

   assign sum = acc + a;
   assign z   = zr;

   // Datapath controls decoded from the current state and the sampled sel
   always_comb begin
      acc_load = 1'b0;
      acc_add  = 1'b0;
      zr_pass  = 1'b0;
      zr_sum   = 1'b0;
      case (state)
         IDLE:       zr_pass  = ~sel;
         ACC0:       acc_load = sel;
         ACC1, ACC2: acc_add  = sel;
         ACC3:       zr_sum   = 1'b1;
         default:    ;
      endcase
   end

   // Control FSM; an aborted frame simply returns to IDLE and its partial sum is dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    state <= sel ? ACC0 : IDLE;
            ACC0:    state <= sel ? ACC1 : IDLE;
            ACC1:    state <= sel ? ACC2 : IDLE;
            ACC2:    state <= sel ? ACC3 : IDLE;
            ACC3:    state <= sel ? ACC0 : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= 8'h00;
      end else if (acc_load) begin
         acc <= a;
      end else if (acc_add) begin
         acc <= sum;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zr <= 8'h00;
      end else if (zr_pass) begin
         zr <= a;
      end else if (zr_sum) begin
         zr <= sum;
      end
   end

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for top: reset, pass-through, accumulate,
// wrap-around, abort, continuous frames and asynchronous mid-frame reset.
module tb_top;

   logic       clk;
   logic       reset;
   logic [7:0] a;
   logic       sel;
   logic [7:0] z;

   int n_compared;
   int n_mismatched;

   top dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .sel   (sel),
      .z     (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a     = 8'hA5;
      sel   = 1'b0;
      #1;
      n_compared++;
      if (z !== 8'h00) begin
         n_mismatched++;
         $display("[TB] FAIL reset_async: z=%h expected=%h", z, 8'h00);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_compared++;
         if (z !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_hold[%0d]: z=%h expected=%h", i, z, 8'h00);
         end
      end
      reset = 1'b0;
      step();
      n_compared++;
      if (z !== 8'hA5) begin
         n_mismatched++;
         $display("[TB] FAIL reset_release: z=%h expected=%h", z, 8'hA5);
      end
   endtask

   task automatic test_pass();
      logic [7:0] vec [3];
      vec[0] = 8'h12;
      vec[1] = 8'h34;
      vec[2] = 8'h56;
      sel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = vec[i];
         step();
         n_compared++;
         if (z !== vec[i]) begin
            n_mismatched++;
            $display("[TB] FAIL pass[%0d]: z=%h expected=%h", i, z, vec[i]);
         end
      end
      // A sel pulse that lies entirely between edges must be ignored
      a   = 8'h9C;
      sel = 1'b1;
      #2;
      sel = 1'b0;
      step();
      n_compared++;
      if (z !== 8'h9C) begin
         n_mismatched++;
         $display("[TB] FAIL sel_glitch: z=%h expected=%h", z, 8'h9C);
      end
   endtask

   // Runs one frame from IDLE: the entry edge plus four samples; sel drops on the
   // last sample so the FSM returns to IDLE
   task automatic run_frame(input string name, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input logic [7:0] prior, input logic [7:0] expected);
      logic [7:0] smp [5];
      smp[0] = 8'hEE;
      smp[1] = s0;
      smp[2] = s1;
      smp[3] = s2;
      smp[4] = s3;
      for (int i = 0; i < 5; i++) begin
         a   = smp[i];
         sel = (i < 4);
         step();
         n_compared++;
         if (i < 4) begin
            if (z !== prior) begin
               n_mismatched++;
               $display("[TB] FAIL %s_hold[%0d]: z=%h expected=%h", name, i, z, prior);
            end
         end else begin
            if (z !== expected) begin
               n_mismatched++;
               $display("[TB] FAIL %s_sum: z=%h expected=%h", name, z, expected);
            end
         end
      end
   endtask

   task automatic test_accumulate();
      run_frame("acc", 8'h01, 8'h02, 8'h03, 8'h04, 8'h9C, 8'h0A);
   endtask

   task automatic test_wrap();
      run_frame("wrap", 8'hFF, 8'h80, 8'h80, 8'h02, 8'h0A, 8'h01);
   endtask

   task automatic test_abort();
      sel = 1'b1;
      a   = 8'h77;
      step();
      a = 8'h10;
      step();
      n_compared++;
      if (z !== 8'h01) begin
         n_mismatched++;
         $display("[TB] FAIL abort_acc0: z=%h expected=%h", z, 8'h01);
      end
      sel = 1'b0;
      a   = 8'h20;
      step();
      n_compared++;
      if (z !== 8'h01) begin
         n_mismatched++;
         $display("[TB] FAIL abort_edge: z=%h expected=%h", z, 8'h01);
      end
      a = 8'h33;
      step();
      n_compared++;
      if (z !== 8'h33) begin
         n_mismatched++;
         $display("[TB] FAIL abort_resume: z=%h expected=%h", z, 8'h33);
      end
      run_frame("reentry", 8'h05, 8'h06, 8'h07, 8'h08, 8'h33, 8'h1A);
   endtask

   task automatic test_back_to_back();
      logic [7:0] smp [8];
      logic [7:0] sum1;
      logic [7:0] sum2;
      logic [7:0] held;
      sum1 = 8'h00;
      sum2 = 8'h00;
      for (int i = 0; i < 8; i++) begin
         smp[i] = 8'($urandom_range(1, 255));
         if (i < 4) sum1 = sum1 + smp[i];
         else       sum2 = sum2 + smp[i];
      end
      held = 8'h1A;
      sel  = 1'b1;
      a    = 8'h44;
      step();
      for (int i = 0; i < 8; i++) begin
         a = smp[i];
         step();
         if (i == 3) held = sum1;
         if (i == 7) held = sum2;
         n_compared++;
         if (z !== held) begin
            n_mismatched++;
            $display("[TB] FAIL b2b[%0d]: z=%h expected=%h", i, z, held);
         end
      end
      // Now in ACC0 with sel high; go two samples deep, then reset between edges
      a = 8'h11;
      step();
      a = 8'h22;
      step();
      #3;
      reset = 1'b1;
      #1;
      n_compared++;
      if (z !== 8'h00) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_reset: z=%h expected=%h", z, 8'h00);
      end
      #3;
      reset = 1'b0;
      sel   = 1'b0;
      a     = 8'h5C;
      step();
      n_compared++;
      if (z !== 8'h5C) begin
         n_mismatched++;
         $display("[TB] FAIL post_reset_idle: z=%h expected=%h", z, 8'h5C);
      end
      run_frame("post_reset", 8'h01, 8'h01, 8'h01, 8'h01, 8'h5C, 8'h04);
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      reset = 1'b1;
      a     = 8'h00;
      sel   = 1'b0;
      test_reset();
      test_pass();
      test_accumulate();
      test_wrap();
      test_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
